// File: rtl/scanline_pkg.sv
// scanline_pkg: constants, types and default palette shared by the scanline
// buffer and its palette lookup.
package scanline_pkg;

    localparam int H_PIXELS_DEF = 848;
    localparam int WORD_W_DEF   = 32;
    localparam int PIX_PER_WORD = WORD_W_DEF / 2;

    // 2-bit colour index as produced by the line generator
    typedef logic [1:0] color_idx_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Write-side fill state
    typedef enum logic {
        WR_FILL = 1'b0,
        WR_DONE = 1'b1
    } wr_state_t;

    localparam rgb_t COL_BLACK = 24'h000000;
    localparam rgb_t COL_RED   = 24'hFF0000;
    localparam rgb_t COL_GREEN = 24'h00FF00;
    localparam rgb_t COL_BLUE  = 24'h0000FF;

    // Number of storage words needed to hold one line
    function automatic int words_per_line(input int h_pixels, input int pix_per_word);
        return (h_pixels + pix_per_word - 1) / pix_per_word;
    endfunction

endpackage

// File: rtl/scanline_palette.sv
// scanline_palette: 2-bit colour index to 24-bit RGB.
// Build option SCANLINE_PALETTE_REG_EN: palette becomes four writable
// registers (reset to the defaults); otherwise a fixed table and the
// pal_* inputs are ignored.
module scanline_palette
    import scanline_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        pal_we,
    input  logic [1:0]  pal_idx,
    input  logic [23:0] pal_rgb,
    input  logic [1:0]  idx,
    output logic [23:0] rgb
);

`ifdef SCANLINE_PALETTE_REG_EN
    rgb_t pal [4];

    // Programmable entries; a write is visible to lookups from the next cycle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pal[0] <= COL_BLACK;
            pal[1] <= COL_RED;
            pal[2] <= COL_GREEN;
            pal[3] <= COL_BLUE;
        end else if (pal_we) begin
            pal[pal_idx] <= pal_rgb;
        end
    end

    assign rgb = pal[idx];
`else
    logic unused_pal;
    assign unused_pal = ^{CLK, RST_N, pal_we, pal_idx, pal_rgb};

    // Fixed default colour table.
    always_comb begin
        rgb = COL_BLACK;
        case (idx)
            2'd0: rgb = COL_BLACK;
            2'd1: rgb = COL_RED;
            2'd2: rgb = COL_GREEN;
            2'd3: rgb = COL_BLUE;
            default: rgb = COL_BLACK;
        endcase
    end
`endif

endmodule

// File: rtl/scanline_buffer.sv
// scanline_buffer: double-buffered line store. Upstream fills one bank with
// 2-bit pixel words while the other bank is streamed out through the palette,
// one pixel per pix_en. Banks swap on line_start when the fill is complete;
// otherwise the old line is shown again and the sticky underrun flag is set.
// Build option SCANLINE_PALETTE_REG_EN selects a writable palette.
module scanline_buffer
    import scanline_pkg::*;
#(
    parameter int H_PIXELS = H_PIXELS_DEF,
    parameter int WORD_W   = WORD_W_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              line_start,
    input  logic              pix_en,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              line_ready,
    output logic              underrun,
    input  logic              underrun_clr,
    input  logic              pal_we,
    input  logic [1:0]        pal_idx,
    input  logic [23:0]       pal_rgb
);

    localparam int PPW   = WORD_W / 2;
    localparam int WPL   = words_per_line(H_PIXELS, PPW);
    localparam int WA_W  = $clog2(WPL);
    localparam int RP_W  = $clog2(H_PIXELS + 1);
    localparam int PS_W  = $clog2(PPW);
    localparam int DEPTH = 2 ** (WA_W + 1);

    wr_state_t         state, state_nxt;
    logic              wbank, rvalid;
    logic [WA_W-1:0]   wcount;
    logic [RP_W-1:0]   rptr, rptr_eff;
    logic              wr_fire, word_done, swap, ur_set;
    logic [WORD_W-1:0] mem [DEPTH];
    logic [WA_W:0]     waddr, raddr;
    logic              rbank_eff, rvalid_eff, show;
    logic [WA_W-1:0]   rword;
    logic [PS_W-1:0]   rsel;
    logic [WORD_W-1:0] rdata;
    color_idx_t        pix_idx;
    rgb_t              pal_out;

    // Write FSM next state; a completing word and line_start in the same
    // cycle still counts as a complete line.
    always_comb begin
        state_nxt  = state;
        wr_ready   = 1'b0;
        line_ready = 1'b0;
        word_done  = 1'b0;
        swap       = 1'b0;
        ur_set     = 1'b0;
        case (state)
            WR_FILL: begin
                wr_ready = 1'b1;
                if (wr_valid && (wr_last || wcount == WA_W'(WPL - 1))) begin
                    word_done = 1'b1;
                    state_nxt = WR_DONE;
                end
            end
            WR_DONE: line_ready = 1'b1;
        endcase
        swap   = line_start && (state == WR_DONE || word_done);
        ur_set = line_start && !swap;
        if (swap) state_nxt = WR_FILL;
    end

    assign wr_fire = wr_valid && wr_ready;

    // Write FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) state <= WR_FILL;
        else        state <= state_nxt;
    end

    // Fill pointer, bank selection, read-bank validity and sticky underrun.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wcount   <= '0;
            wbank    <= 1'b0;
            rvalid   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (swap) begin
                wcount <= '0;
                wbank  <= ~wbank;
                rvalid <= 1'b1;
            end else if (wr_fire) begin
                wcount <= wcount + 1'b1;
            end
            if (ur_set)            underrun <= 1'b1;
            else if (underrun_clr) underrun <= 1'b0;
        end
    end

    assign waddr = {wbank, wcount};

    // Line storage, two banks addressed {bank, word}; contents are not reset.
    always_ff @(posedge CLK) begin
        if (RST_N && wr_fire) mem[waddr] <= wr_data;
    end

    // On a swapping line_start the pixel read this cycle already comes from
    // the freshly completed bank at position 0.
    assign rptr_eff   = line_start ? '0 : rptr;
    assign rbank_eff  = swap ? wbank : ~wbank;
    assign rvalid_eff = swap | rvalid;
    assign rword      = WA_W'(rptr_eff >> PS_W);
    assign rsel       = rptr_eff[PS_W-1:0];
    assign raddr      = {rbank_eff, rword};
    // Forward a word being written into the bank that is swapping in now.
    assign rdata      = (wr_fire && waddr == raddr) ? wr_data : mem[raddr];
    assign pix_idx    = color_idx_t'(rdata >> {rsel, 1'b0});
    assign show       = pix_en && rvalid_eff && (rptr_eff < RP_W'(H_PIXELS));

    // Read pointer: restarts on line_start, saturates at end of line.
    always_ff @(posedge CLK) begin
        if (!RST_N)                                     rptr <= '0;
        else if (line_start)                            rptr <= pix_en ? RP_W'(1) : '0;
        else if (pix_en && rptr < RP_W'(H_PIXELS))      rptr <= rptr + 1'b1;
    end

    scanline_palette u_pal (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .pal_we  (pal_we),
        .pal_idx (pal_idx),
        .pal_rgb (pal_rgb),
        .idx     (pix_idx),
        .rgb     (pal_out)
    );

    // Registered colour output; black outside valid active pixels.
    always_ff @(posedge CLK) begin
        if (!RST_N || !show) begin
            red   <= 8'h00;
            green <= 8'h00;
            blue  <= 8'h00;
        end else begin
            red   <= pal_out.r;
            green <= pal_out.g;
            blue  <= pal_out.b;
        end
    end

endmodule

// File: tb/tb_scanline_buffer.sv
// tb_scanline_buffer: table-driven line patterns plus hand sequences for
// underrun, same-cycle completion, overfill, palette write and mid-line reset.
// Pixel outputs go through a scoreboard queue fed by a two-bank line model.
module tb_scanline_buffer;
    import scanline_pkg::*;

    localparam int H   = 848;
    localparam int WPL = 53;
    localparam logic [23:0] BLK = 24'h000000;
    localparam logic [23:0] RED = 24'hFF0000;
    localparam logic [23:0] GRN = 24'h00FF00;
    localparam logic [23:0] BLU = 24'h0000FF;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        wr_valid = 1'b0, wr_last = 1'b0, line_start = 1'b0, pix_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        underrun_clr = 1'b0, pal_we = 1'b0;
    logic [1:0]  pal_idx = '0;
    logic [23:0] pal_rgb = '0;
    logic        wr_ready, line_ready, underrun;
    logic [7:0]  red, green, blue;

    scanline_buffer dut (
        .CLK(CLK), .RST_N(RST_N), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_last(wr_last), .line_start(line_start),
        .pix_en(pix_en), .red(red), .green(green), .blue(blue),
        .line_ready(line_ready), .underrun(underrun), .underrun_clr(underrun_clr),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb)
    );

    always #5 CLK = ~CLK;

    // model state
    logic [31:0] mb [2][WPL];
    int          m_wb, m_wn, m_rp;
    bit          m_done, m_rv;
    logic [23:0] tpal [4];
    logic [23:0] sb [$];
    logic [23:0] cap [1024];
    int          checks = 0, errors = 0;

    typedef struct {
        logic [31:0] w0;
        logic [31:0] wrest;
        bit          use_last;
        bit          with_pix;
        logic [23:0] p0, p1, p847;
    } vec_t;
    vec_t vt [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_init();
        m_wb = 0; m_wn = 0; m_rp = 0; m_done = 0; m_rv = 0;
        tpal[0] = BLK; tpal[1] = RED; tpal[2] = GRN; tpal[3] = BLU;
    endtask

    task automatic do_reset();
        RST_N = 1'b0; wr_valid = 0; wr_last = 0; line_start = 0; pix_en = 0;
        underrun_clr = 0; pal_we = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst wr_ready", 32'(wr_ready), 1);
        chk("rst line_ready", 32'(line_ready), 0);
        chk("rst underrun", 32'(underrun), 0);
        chk("rst rgb", {8'h0, red, green, blue}, 0);
        RST_N = 1'b1;
        model_init();
    endtask

    // One clock: drive, predict, advance, compare the popped expectation.
    task automatic cyc(input bit ls, input bit en, input bit wv, input logic [31:0] wd,
                       input bit wl, input int ci);
        logic [31:0] w;
        logic [1:0]  ix;
        logic [23:0] e;
        bit acc, compl, rv;
        int rb;
        line_start = ls; pix_en = en; wr_valid = wv; wr_data = wd; wr_last = wl;
        chk("wr_ready", 32'(wr_ready), 32'(!m_done));
        chk("line_ready", 32'(line_ready), 32'(m_done));
        acc   = wv && !m_done;
        compl = m_done || (acc && (wl || m_wn == WPL - 1));
        if (acc) mb[m_wb][m_wn] = wd;
        if (ls) m_rp = 0;
        rb = (ls && compl) ? m_wb : 1 - m_wb;
        rv = m_rv || (ls && compl);
        e  = BLK;
        if (en && rv && m_rp < H) begin
            w  = mb[rb][m_rp / 16];
            ix = w[2 * (m_rp % 16) +: 2];
            e  = tpal[ix];
        end
        if (en && m_rp < H) m_rp++;
        if (acc) begin
            m_wn++;
            if (wl || m_wn == WPL) m_done = 1;
        end
        if (ls && compl) begin
            m_wb = 1 - m_wb; m_rv = 1; m_wn = 0; m_done = 0;
        end
`ifdef SCANLINE_PALETTE_REG_EN
        if (pal_we) tpal[pal_idx] = pal_rgb;
`endif
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk("rgb", {8'h0, red, green, blue}, {8'h0, e});
        if (ci >= 0) cap[ci] = {red, green, blue};
    endtask

    task automatic write_words(input logic [31:0] w0, input logic [31:0] wrest,
                               input int nw, input bit last);
        for (int i = 0; i < nw; i++)
            cyc(1'b0, 1'b0, 1'b1, (i == 0) ? w0 : wrest, last && (i == nw - 1), -1);
    endtask

    // line_start (optionally with pixel 0 and a write), then a run of pix_en.
    task automatic stream(input bit with_pix, input bit wv0, input logic [31:0] wd0,
                          input bit wl0, input int n);
        cyc(1'b1, with_pix, wv0, wd0, wl0, with_pix ? 0 : -1);
        for (int i = with_pix ? 1 : 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nacc;
        logic [23:0] pal_exp;
        vt[0] = '{32'h55555555, 32'h55555555, 1'b0, 1'b0, RED, RED, RED};
        vt[1] = '{32'h0000000E, 32'h00000000, 1'b1, 1'b1, GRN, BLU, BLK};
        vt[2] = '{32'h00000007, 32'h00000000, 1'b1, 1'b0, BLU, RED, BLK};
        vt[3] = '{32'hE4E4E4E4, 32'hE4E4E4E4, 1'b0, 1'b1, BLK, RED, BLU};

        do_reset();

        // line_start with nothing written: black, underrun; set beats clear
        cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, 0);
        chk("empty underrun", 32'(underrun), 1);
        chk("empty pix0", {8'h0, cap[0]}, 0);
        underrun_clr = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, -1);
        chk("set wins", 32'(underrun), 1);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, -1);
        underrun_clr = 1'b0;
        chk("clear", 32'(underrun), 0);

        for (int r = 0; r < 4; r++) begin
            write_words(vt[r].w0, vt[r].wrest, WPL, vt[r].use_last);
            chk("tbl line_ready", 32'(line_ready), 1);
            chk("tbl wr_ready", 32'(wr_ready), 0);
            stream(vt[r].with_pix, 1'b0, '0, 1'b0, 860);
            chk("tbl p0", {8'h0, cap[0]}, {8'h0, vt[r].p0});
            chk("tbl p1", {8'h0, cap[1]}, {8'h0, vt[r].p1});
            chk("tbl p847", {8'h0, cap[847]}, {8'h0, vt[r].p847});
            chk("tbl p848", {8'h0, cap[848]}, 0);
            chk("tbl p859", {8'h0, cap[859]}, 0);
            chk("tbl underrun", 32'(underrun), 0);
        end

        // partial line at line_start: old line repeats, fill resumes at word 40
        write_words(32'h55555555, 32'h55555555, 40, 1'b0);
        stream(1'b1, 1'b0, '0, 1'b0, 860);
        chk("ur flag", 32'(underrun), 1);
        chk("ur p1", {8'h0, cap[1]}, {8'h0, RED});
        chk("ur p2", {8'h0, cap[2]}, {8'h0, GRN});
        chk("ur p847", {8'h0, cap[847]}, {8'h0, BLU});
        chk("ur resume", 32'(wr_ready), 1);
        write_words(32'hFFFFFFFF, 32'h55555555, 13, 1'b1);
        stream(1'b0, 1'b0, '0, 1'b0, 860);
        chk("ur new p0", {8'h0, cap[0]}, {8'h0, RED});
        chk("ur new p640", {8'h0, cap[640]}, {8'h0, BLU});
        chk("ur new p656", {8'h0, cap[656]}, {8'h0, RED});
        underrun_clr = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, -1);
        underrun_clr = 1'b0;
        chk("ur cleared", 32'(underrun), 0);

        // last word accepted together with line_start
        write_words(32'hAAAAAAAA, 32'hAAAAAAAA, 52, 1'b0);
        stream(1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 860);
        chk("same underrun", 32'(underrun), 0);
        chk("same p0", {8'h0, cap[0]}, {8'h0, GRN});
        chk("same p831", {8'h0, cap[831]}, {8'h0, GRN});
        chk("same p840", {8'h0, cap[840]}, {8'h0, BLU});

        // wr_valid held with no wr_last: exactly one line of words accepted
        nacc = 0;
        for (int i = 0; i < 70; i++) begin
            if (wr_ready) nacc++;
            cyc(1'b0, 1'b0, 1'b1, 32'hAAAAAAAA, 1'b0, -1);
        end
        chk("overfill count", 32'(nacc), 53);
        chk("overfill wr_ready", 32'(wr_ready), 0);
        chk("overfill line_ready", 32'(line_ready), 1);

        // palette write mid-line on an all-index-2 line
        cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, 0);
        chk("post swap wr_ready", 32'(wr_ready), 1);
        for (int i = 1; i < 100; i++) cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, i);
        pal_we = 1'b1; pal_idx = 2'd2; pal_rgb = 24'h123456;
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, 100);
        pal_we = 1'b0;
        for (int i = 101; i < 860; i++) cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, i);
`ifdef SCANLINE_PALETTE_REG_EN
        pal_exp = 24'h123456;
`else
        pal_exp = GRN;
`endif
        chk("pal before", {8'h0, cap[99]}, {8'h0, GRN});
        chk("pal after", {8'h0, cap[101]}, {8'h0, pal_exp});

        // reset mid-line drops the partial line and restores the palette
        write_words(32'h55555555, 32'h55555555, 20, 1'b0);
        do_reset();
        stream(1'b1, 1'b0, '0, 1'b0, 20);
        chk("rst ur", 32'(underrun), 1);
        chk("rst black", {8'h0, cap[5]}, 0);
        write_words(32'hAAAAAAAA, 32'hAAAAAAAA, WPL, 1'b0);
        stream(1'b0, 1'b0, '0, 1'b0, 860);
        chk("rst pal p3", {8'h0, cap[3]}, {8'h0, GRN});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
